commit_trace_checker: RTL and testbench

COMMIT_TRACE_CHECKER -- requirements
Module: commit_trace_checker

---
 rtl/commit_trace_checker.sv | 149 ++++++++++++++
 tb/tb_commit_trace_checker.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_checker.sv
// Commit trace checker: queues expected retirement records and compares each
// retired instruction against the oldest one, latching PASS on halt or FAIL on divergence.
module commit_trace_checker #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        exp_valid,
    output logic        exp_ready,
    input  logic [15:0] exp_pc,
    input  logic        exp_rw,
    input  logic        exp_mw,
    input  logic        exp_halt,
    input  logic [2:0]  exp_reg,
    input  logic [15:0] exp_rdata,
    input  logic [15:0] exp_addr,
    input  logic [15:0] exp_mdata,
    input  logic        cmt_valid,
    input  logic [15:0] cmt_pc,
    input  logic        cmt_rw,
    input  logic        cmt_mw,
    input  logic        cmt_halt,
    input  logic [2:0]  cmt_reg,
    input  logic [15:0] cmt_rdata,
    input  logic [15:0] cmt_addr,
    input  logic [15:0] cmt_mdata,
    output logic [1:0]  state,
    output logic [1:0]  err_code,
    output logic [15:0] inst_count,
    output logic [15:0] fail_pc
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {
        RUN  = 2'b00,
        PASS = 2'b01,
        FAIL = 2'b10
    } state_e;

    typedef struct packed {
        logic [15:0] pc;
        logic        rw;
        logic        mw;
        logic        halt;
        logic [2:0]  rdst;
        logic [15:0] rdata;
        logic [15:0] addr;
        logic [15:0] mdata;
    } rec_t;

    state_e        state_q, state_d;
    logic [1:0]    err_q, err_d;
    logic [15:0]   inst_count_q, inst_count_d;
    logic [15:0]   fail_pc_q, fail_pc_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    rec_t          mem_q [DEPTH];

    rec_t exp_rec, cmt_rec, head;
    logic full, empty, push, pop;

    // Register/memory payloads only matter when the corresponding write flag is set.
    function automatic logic rec_match(input rec_t e, input rec_t c);
        logic ok;
        ok = (e.pc == c.pc) && (e.rw == c.rw) && (e.mw == c.mw) && (e.halt == c.halt);
        if (e.rw)
            ok = ok && (e.rdst == c.rdst) && (e.rdata == c.rdata);
        if (e.mw)
            ok = ok && (e.addr == c.addr) && (e.mdata == c.mdata);
        return ok;
    endfunction

    assign exp_rec = '{exp_pc, exp_rw, exp_mw, exp_halt, exp_reg, exp_rdata, exp_addr, exp_mdata};
    assign cmt_rec = '{cmt_pc, cmt_rw, cmt_mw, cmt_halt, cmt_reg, cmt_rdata, cmt_addr, cmt_mdata};
    assign head    = mem_q[rd_ptr_q];
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);

    // rst_n gates ready so nothing is accepted in a reset cycle.
    assign exp_ready = rst_n & (state_q == RUN) & ~full;
    assign push      = exp_valid & exp_ready;

    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        inst_count_d = inst_count_q;
        fail_pc_d    = fail_pc_q;
        pop          = 1'b0;
        if (state_q == RUN && cmt_valid) begin
            if (empty) begin
                state_d   = FAIL;
                err_d     = 2'b01;
                fail_pc_d = cmt_pc;
            end else if (rec_match(head, cmt_rec)) begin
                pop = 1'b1;
                if (inst_count_q != 16'hFFFF)
                    inst_count_d = inst_count_q + 16'd1;
                if (head.halt)
                    state_d = PASS;
            end else begin
                state_d   = FAIL;
                err_d     = 2'b10;
                fail_pc_d = cmt_pc;
            end
        end

        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= RUN;
            err_q        <= 2'b00;
            inst_count_q <= '0;
            fail_pc_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            inst_count_q <= inst_count_d;
            fail_pc_q    <= fail_pc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= exp_rec;
    end

    assign state      = state_q;
    assign err_code   = err_q;
    assign inst_count = inst_count_q;
    assign fail_pc    = fail_pc_q;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Bench for commit_trace_checker: a vector table of single-cycle stimulus with expected
// outputs, plus a FIFO-wrap sequence driven from a scoreboard of queued records.
module tb_commit_trace_checker;
    localparam logic [1:0] S_RUN  = 2'b00;
    localparam logic [1:0] S_PASS = 2'b01;
    localparam logic [1:0] S_FAIL = 2'b10;
    localparam int NV = 29;

    typedef struct packed {
        logic [15:0] pc;
        logic        rw;
        logic        mw;
        logic        halt;
        logic [2:0]  rdst;
        logic [15:0] rdata;
        logic [15:0] addr;
        logic [15:0] mdata;
    } rec_t;

    typedef struct packed {
        logic        rst_n;
        logic        ev;
        rec_t        e;
        logic        cv;
        rec_t        c;
        logic        x_rdy;
        logic [1:0]  x_state;
        logic [1:0]  x_err;
        logic [15:0] x_cnt;
        logic [15:0] x_fpc;
    } vec_t;

    logic        clk, rst_n;
    logic        exp_valid, exp_ready;
    logic [15:0] exp_pc, exp_rdata, exp_addr, exp_mdata;
    logic        exp_rw, exp_mw, exp_halt;
    logic [2:0]  exp_reg;
    logic        cmt_valid;
    logic [15:0] cmt_pc, cmt_rdata, cmt_addr, cmt_mdata;
    logic        cmt_rw, cmt_mw, cmt_halt;
    logic [2:0]  cmt_reg;
    logic [1:0]  state, err_code;
    logic [15:0] inst_count, fail_pc;

    int nchk = 0;
    int nerr = 0;

    vec_t tbl [NV];
    vec_t expq [$];
    rec_t sb [$];

    commit_trace_checker #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .exp_valid(exp_valid), .exp_ready(exp_ready),
        .exp_pc(exp_pc), .exp_rw(exp_rw), .exp_mw(exp_mw), .exp_halt(exp_halt),
        .exp_reg(exp_reg), .exp_rdata(exp_rdata), .exp_addr(exp_addr), .exp_mdata(exp_mdata),
        .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_rw(cmt_rw), .cmt_mw(cmt_mw),
        .cmt_halt(cmt_halt), .cmt_reg(cmt_reg), .cmt_rdata(cmt_rdata),
        .cmt_addr(cmt_addr), .cmt_mdata(cmt_mdata),
        .state(state), .err_code(err_code), .inst_count(inst_count), .fail_pc(fail_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic rec_t R(input logic [15:0] pc, input logic rw, input logic mw,
                               input logic halt, input logic [2:0] rd, input logic [15:0] rdata,
                               input logic [15:0] addr, input logic [15:0] mdata);
        rec_t r;
        r.pc = pc; r.rw = rw; r.mw = mw; r.halt = halt; r.rdst = rd;
        r.rdata = rdata; r.addr = addr; r.mdata = mdata;
        return r;
    endfunction

    function automatic vec_t V(input logic rs, input logic ev, input rec_t e, input logic cv,
                               input rec_t c, input logic rdy, input logic [1:0] st,
                               input logic [1:0] er, input logic [15:0] cnt, input logic [15:0] fpc);
        vec_t v;
        v.rst_n = rs; v.ev = ev; v.e = e; v.cv = cv; v.c = c; v.x_rdy = rdy;
        v.x_state = st; v.x_err = er; v.x_cnt = cnt; v.x_fpc = fpc;
        return v;
    endfunction

    function automatic rec_t gen(input int i);
        rec_t r;
        r.pc    = 16'h0100 + 16'(2 * i);
        r.rw    = (i % 2 == 0);
        r.mw    = (i % 2 == 1);
        r.halt  = (i == 9);
        r.rdst  = 3'(i);
        r.rdata = 16'h1000 + 16'(i);
        r.addr  = 16'h0200 + 16'(i);
        r.mdata = 16'hA000 ^ 16'(i);
        return r;
    endfunction

    task automatic drive(input logic rs, input logic ev, input rec_t e, input logic cv, input rec_t c);
        @(negedge clk);
        rst_n = rs;
        exp_valid = ev; exp_pc = e.pc; exp_rw = e.rw; exp_mw = e.mw; exp_halt = e.halt;
        exp_reg = e.rdst; exp_rdata = e.rdata; exp_addr = e.addr; exp_mdata = e.mdata;
        cmt_valid = cv; cmt_pc = c.pc; cmt_rw = c.rw; cmt_mw = c.mw; cmt_halt = c.halt;
        cmt_reg = c.rdst; cmt_rdata = c.rdata; cmt_addr = c.addr; cmt_mdata = c.mdata;
    endtask

    task automatic chk(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s step %0d: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    initial begin
        rec_t z, r1, r2, r3, b1, c1, c2, d1, e1, e2, e3, f1;
        vec_t v;
        z  = '0;
        r1 = R(16'h0000, 1, 0, 0, 3'd1, 16'h0005, 16'h0000, 16'h0000);
        r2 = R(16'h0002, 0, 1, 0, 3'd0, 16'h0000, 16'h0010, 16'h0005);
        r3 = R(16'h0004, 0, 0, 1, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        b1 = R(16'h0000, 1, 0, 0, 3'd2, 16'h1234, 16'h0000, 16'h0000);
        c1 = R(16'h0010, 1, 0, 0, 3'd3, 16'hAAAA, 16'h0000, 16'h0000);
        c2 = R(16'h0012, 0, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        d1 = R(16'h0008, 0, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        e1 = R(16'h0020, 0, 0, 0, 3'd5, 16'hDEAD, 16'hBEEF, 16'h1111);
        e2 = R(16'h0022, 0, 1, 0, 3'd7, 16'h5555, 16'h0040, 16'h0077);
        e3 = R(16'h0024, 0, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000);
        f1 = R(16'h0030, 0, 1, 0, 3'd0, 16'h0000, 16'h0050, 16'h0060);

        // three-record program ending in halt, then terminal PASS
        tbl[0]  = V(0, 0, z,  0, z,  0, S_RUN,  2'b00, 16'd0, 16'h0000);
        tbl[1]  = V(1, 1, r1, 0, z,  1, S_RUN,  2'b00, 16'd0, 16'h0000);
        tbl[2]  = V(1, 1, r2, 0, z,  1, S_RUN,  2'b00, 16'd0, 16'h0000);
        tbl[3]  = V(1, 1, r3, 1, r1, 1, S_RUN,  2'b00, 16'd1, 16'h0000);
        tbl[4]  = V(1, 0, z,  1, r2, 1, S_RUN,  2'b00, 16'd2, 16'h0000);
        tbl[5]  = V(1, 0, z,  1, r3, 1, S_PASS, 2'b00, 16'd3, 16'h0000);
        tbl[6]  = V(1, 1, r1, 1, R(16'h0099, 1, 1, 1, 3'd7, 16'hFFFF, 16'hFFFF, 16'hFFFF),
                    0, S_PASS, 2'b00, 16'd3, 16'h0000);
        // register-value mismatch, then FAIL holds
        tbl[7]  = V(0, 1, r1, 1, r1, 0, S_RUN,  2'b00, 16'd0, 16'h0000);
        tbl[8]  = V(1, 1, b1, 0, z,  1, S_RUN,  2'b00, 16'd0, 16'h0000);
        tbl[9]  = V(1, 0, z,  1, R(16'h0000, 1, 0, 0, 3'd2, 16'h1235, 16'h0000, 16'h0000),
                    1, S_FAIL, 2'b10, 16'd0, 16'h0000);
        tbl[10] = V(1, 1, b1, 1, b1, 0, S_FAIL, 2'b10, 16'd0, 16'h0000);
        // reset with two records queued must empty the FIFO
        tbl[11] = V(0, 0, z,  0, z,  0, S_RUN,  2'b00, 16'd0, 16'h0000);
        tbl[12] = V(1, 1, c1, 0, z,  1, S_RUN,  2'b00, 16'd0, 16'h0000);
        tbl[13] = V(1, 1, c2, 0, z,  1, S_RUN,  2'b00, 16'd0, 16'h0000);
        tbl[14] = V(1, 0, z,  1, R(16'h0010, 1, 0, 0, 3'd3, 16'hAAAB, 16'h0000, 16'h0000),
                    1, S_FAIL, 2'b10, 16'd0, 16'h0010);
        tbl[15] = V(0, 1, c1, 1, c1, 0, S_RUN,  2'b00, 16'd0, 16'h0000);
        tbl[16] = V(1, 0, z,  1, c2, 1, S_FAIL, 2'b01, 16'd0, 16'h0012);
        // underflow with a same-cycle push (no bypass)
        tbl[17] = V(0, 0, z,  0, z,  0, S_RUN,  2'b00, 16'd0, 16'h0000);
        tbl[18] = V(1, 1, d1, 1, d1, 1, S_FAIL, 2'b01, 16'd0, 16'h0008);
        // payloads ignored when their write flag is clear; flag mismatch fails
        tbl[19] = V(0, 0, z,  0, z,  0, S_RUN,  2'b00, 16'd0, 16'h0000);
        tbl[20] = V(1, 1, e1, 0, z,  1, S_RUN,  2'b00, 16'd0, 16'h0000);
        tbl[21] = V(1, 0, z,  1, R(16'h0020, 0, 0, 0, 3'd2, 16'h0000, 16'h0000, 16'h2222),
                    1, S_RUN, 2'b00, 16'd1, 16'h0000);
        tbl[22] = V(1, 1, e2, 0, z,  1, S_RUN,  2'b00, 16'd1, 16'h0000);
        tbl[23] = V(1, 0, z,  1, R(16'h0022, 0, 1, 0, 3'd1, 16'h0000, 16'h0040, 16'h0077),
                    1, S_RUN, 2'b00, 16'd2, 16'h0000);
        tbl[24] = V(1, 1, e3, 0, z,  1, S_RUN,  2'b00, 16'd2, 16'h0000);
        tbl[25] = V(1, 0, z,  1, R(16'h0024, 1, 0, 0, 3'd0, 16'h0000, 16'h0000, 16'h0000),
                    1, S_FAIL, 2'b10, 16'd2, 16'h0024);
        // store-data mismatch
        tbl[26] = V(0, 0, z,  0, z,  0, S_RUN,  2'b00, 16'd0, 16'h0000);
        tbl[27] = V(1, 1, f1, 0, z,  1, S_RUN,  2'b00, 16'd0, 16'h0000);
        tbl[28] = V(1, 0, z,  1, R(16'h0030, 0, 1, 0, 3'd0, 16'h0000, 16'h0050, 16'h0061),
                    1, S_FAIL, 2'b10, 16'd0, 16'h0030);

        for (int i = 0; i < NV; i++) begin
            drive(tbl[i].rst_n, tbl[i].ev, tbl[i].e, tbl[i].cv, tbl[i].c);
            #1;
            chk("exp_ready", i, 16'(exp_ready), 16'(tbl[i].x_rdy));
            expq.push_back(tbl[i]);
            @(posedge clk);
            #1;
            v = expq.pop_front();
            chk("state", i, 16'(state), 16'(v.x_state));
            chk("err_code", i, 16'(err_code), 16'(v.x_err));
            chk("inst_count", i, inst_count, v.x_cnt);
            chk("fail_pc", i, fail_pc, v.x_fpc);
        end

        // FIFO fill, back-pressure and pointer wrap over ten records
        begin
            int pushed, retired;
            logic ev_l, cv_l, rdy_x;
            rec_t er, cr;
            pushed = 0;
            retired = 0;
            drive(0, 0, z, 0, z);
            @(posedge clk);
            #1;
            for (int cyc = 0; cyc < 40 && retired < 10; cyc++) begin
                ev_l  = (pushed < 10);
                er    = ev_l ? gen(pushed) : z;
                cv_l  = (cyc >= 4) && (sb.size() > 0);
                cr    = cv_l ? sb[0] : z;
                rdy_x = (sb.size() < 4);
                drive(1, ev_l, er, cv_l, cr);
                #1;
                chk("wrap_ready", cyc, 16'(exp_ready), 16'(rdy_x));
                @(posedge clk);
                #1;
                if (cv_l) begin
                    void'(sb.pop_front());
                    retired++;
                end
                if (ev_l && rdy_x) begin
                    sb.push_back(er);
                    pushed++;
                end
                chk("wrap_count", cyc, inst_count, 16'(retired));
                chk("wrap_state", cyc, 16'(state), (retired == 10) ? 16'(S_PASS) : 16'(S_RUN));
                chk("wrap_err", cyc, 16'(err_code), 16'd0);
            end
            chk("wrap_done", 0, 16'(retired), 16'd10);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
